// File: rtl/z16_pkg.sv
// z16_pkg: shared constants for the Z16 data-memory path.
//   Z16_ADDR_W / Z16_DATA_W : word address and data widths
//   PORT_CPU / PORT_DMA     : arbiter port indices (CPU load/store, DMA/debug)
//   Z16_RUN_W               : width of the burst run counter
package z16_pkg;

  localparam int Z16_ADDR_W = 16;
  localparam int Z16_DATA_W = 16;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  localparam int Z16_RUN_W = 4;

endpackage

// File: rtl/z16_rr_pick.sv
// z16_rr_pick: combinational 2-way round-robin picker with burst hold.
//   req[1:0]        : per-port request
//   last_gnt        : port granted most recently
//   run_cnt         : consecutive grants given to last_gnt
//   prev_gnt_valid  : a grant was issued in the previous cycle
//   gnt[1:0]        : one-hot grant (all zero when nobody requests)
module z16_rr_pick
  import z16_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic [1:0]           req,
  input  logic                 last_gnt,
  input  logic [Z16_RUN_W-1:0] run_cnt,
  input  logic                 prev_gnt_valid,
  output logic [1:0]           gnt
);

  localparam logic [Z16_RUN_W-1:0] MAX_BURST_C = Z16_RUN_W'(MAX_BURST);

  logic win;

  always_comb begin
    gnt = 2'b00;
    win = 1'b0;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        // Keep the current owner only while its burst is still live (it was
        // granted last cycle and has not used up its run); otherwise rotate.
        if (prev_gnt_valid && (run_cnt < MAX_BURST_C)) begin
          win = last_gnt;
        end else begin
          win = ~last_gnt;
        end
        gnt = win ? 2'b10 : 2'b01;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/z16_dmem_arbiter.sv
// z16_dmem_arbiter: shares the single-ported Z16 data memory between the CPU
// load/store unit (port 0) and a DMA/debug master (port 1).
//   i_clk, i_rst_n            : clock (rising edge), async active-low reset
//   i_pN_req/wen/addr/wdata   : port N access request (held until granted)
//   o_pN_gnt                  : combinational grant for port N
//   o_pN_rvalid / o_pN_rdata  : registered read response, 1 cycle after grant
//   o_mem_addr/wen/wdata      : memory pins, muxed from the granted port
//   i_mem_rdata               : memory read data (combinational on address)
module z16_dmem_arbiter
  import z16_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_p0_req,
  input  logic                  i_p0_wen,
  input  logic [Z16_ADDR_W-1:0] i_p0_addr,
  input  logic [Z16_DATA_W-1:0] i_p0_wdata,
  input  logic                  i_p1_req,
  input  logic                  i_p1_wen,
  input  logic [Z16_ADDR_W-1:0] i_p1_addr,
  input  logic [Z16_DATA_W-1:0] i_p1_wdata,
  output logic                  o_p0_gnt,
  output logic                  o_p1_gnt,
  output logic                  o_p0_rvalid,
  output logic                  o_p1_rvalid,
  output logic [Z16_DATA_W-1:0] o_p0_rdata,
  output logic [Z16_DATA_W-1:0] o_p1_rdata,
  output logic [Z16_ADDR_W-1:0] o_mem_addr,
  output logic                  o_mem_wen,
  output logic [Z16_DATA_W-1:0] o_mem_wdata,
  input  logic [Z16_DATA_W-1:0] i_mem_rdata
);

  localparam logic [Z16_RUN_W-1:0] MAX_BURST_C = Z16_RUN_W'(MAX_BURST);

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic [1:0]            wen;
  logic [Z16_ADDR_W-1:0] addr  [2];
  logic [Z16_DATA_W-1:0] wdata [2];

  logic                  any_gnt;
  logic                  gnt_port;

  logic                  last_gnt_q, last_gnt_d;
  logic [Z16_RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic                  prev_gnt_valid_q, prev_gnt_valid_d;

  logic                  rvalid_q [2];
  logic                  rvalid_d [2];
  logic [Z16_DATA_W-1:0] rdata_q  [2];
  logic [Z16_DATA_W-1:0] rdata_d  [2];

  assign req             = {i_p1_req, i_p0_req};
  assign wen             = {i_p1_wen, i_p0_wen};
  assign addr[PORT_CPU]  = i_p0_addr;
  assign addr[PORT_DMA]  = i_p1_addr;
  assign wdata[PORT_CPU] = i_p0_wdata;
  assign wdata[PORT_DMA] = i_p1_wdata;

  z16_rr_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .req            (req),
    .last_gnt       (last_gnt_q),
    .run_cnt        (run_cnt_q),
    .prev_gnt_valid (prev_gnt_valid_q),
    .gnt            (gnt)
  );

  assign any_gnt  = |gnt;
  assign gnt_port = gnt[PORT_DMA];
  assign o_p0_gnt = gnt[PORT_CPU];
  assign o_p1_gnt = gnt[PORT_DMA];

  // Memory pins idle at zero so the memory never sees a stray write.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    if (any_gnt) begin
      o_mem_addr  = addr[gnt_port];
      o_mem_wen   = wen[gnt_port];
      o_mem_wdata = wdata[gnt_port];
    end
  end

  // Arbitration state: a run continues only across back-to-back grants to
  // the same port; any idle cycle or port change restarts it.
  always_comb begin
    last_gnt_d       = last_gnt_q;
    run_cnt_d        = '0;
    prev_gnt_valid_d = any_gnt;
    if (any_gnt) begin
      last_gnt_d = gnt_port;
      if (prev_gnt_valid_q && (gnt_port == last_gnt_q)) begin
        run_cnt_d = (run_cnt_q >= MAX_BURST_C) ? MAX_BURST_C : run_cnt_q + 1'b1;
      end else begin
        run_cnt_d = Z16_RUN_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_gnt_q       <= 1'b1;  // port 0 wins the first contention
      run_cnt_q        <= '0;
      prev_gnt_valid_q <= 1'b0;
    end else begin
      last_gnt_q       <= last_gnt_d;
      run_cnt_q        <= run_cnt_d;
      prev_gnt_valid_q <= prev_gnt_valid_d;
    end
  end

  // Per-port read capture: memory data is sampled at the grant edge and
  // held until that port's next read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    always_comb begin
      rvalid_d[gi] = gnt[gi] & ~wen[gi];
      rdata_d[gi]  = rvalid_d[gi] ? i_mem_rdata : rdata_q[gi];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rvalid_q[gi] <= 1'b0;
        rdata_q[gi]  <= '0;
      end else begin
        rvalid_q[gi] <= rvalid_d[gi];
        rdata_q[gi]  <= rdata_d[gi];
      end
    end
  end

  assign o_p0_rvalid = rvalid_q[PORT_CPU];
  assign o_p1_rvalid = rvalid_q[PORT_DMA];
  assign o_p0_rdata  = rdata_q[PORT_CPU];
  assign o_p1_rdata  = rdata_q[PORT_DMA];

endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// Bench for z16_dmem_arbiter: two instances (MAX_BURST = 4 and 1) share the
// same stimulus; each has its own behavioural memory. Slot s = inst*2 + port.
module tb_z16_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        p0_req, p0_wen, p1_req, p1_wen;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  logic        g   [4];
  logic        rv  [4];
  logic [15:0] rd  [4];
  logic [15:0] m_addr  [2];
  logic        m_wen   [2];
  logic [15:0] m_wdata [2];
  logic [15:0] m_rdata [2];

  logic [15:0] mem [2][1024];

  typedef struct {
    int          stamp;
    logic [15:0] data;
  } exp_t;

  exp_t sb [4][$];

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h1234;
  endfunction

  // Memory refills with the address pattern while reset is held.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int a = 0; a < 1024; a++) mem[k][a] <= pat(16'(a));
      end else if (m_wen[k]) begin
        mem[k][m_addr[k][9:0]] <= m_wdata[k];
      end
    end
  end

  assign m_rdata[0] = mem[0][m_addr[0][9:0]];
  assign m_rdata[1] = mem[1][m_addr[1][9:0]];

  z16_dmem_arbiter #(.MAX_BURST(4)) u_max4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p0_req(p0_req), .i_p0_wen(p0_wen), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .i_p1_req(p1_req), .i_p1_wen(p1_wen), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .o_p0_gnt(g[0]), .o_p1_gnt(g[1]),
    .o_p0_rvalid(rv[0]), .o_p1_rvalid(rv[1]),
    .o_p0_rdata(rd[0]), .o_p1_rdata(rd[1]),
    .o_mem_addr(m_addr[0]), .o_mem_wen(m_wen[0]), .o_mem_wdata(m_wdata[0]),
    .i_mem_rdata(m_rdata[0])
  );

  z16_dmem_arbiter #(.MAX_BURST(1)) u_max1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p0_req(p0_req), .i_p0_wen(p0_wen), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .i_p1_req(p1_req), .i_p1_wen(p1_wen), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .o_p0_gnt(g[2]), .o_p1_gnt(g[3]),
    .o_p0_rvalid(rv[2]), .o_p1_rvalid(rv[3]),
    .o_p0_rdata(rd[2]), .o_p1_rdata(rd[3]),
    .o_mem_addr(m_addr[1]), .o_mem_wen(m_wen[1]), .o_mem_wdata(m_wdata[1]),
    .i_mem_rdata(m_rdata[1])
  );

  task automatic set_in(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
    p0_req = r0; p0_wen = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_wen = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  // Scoreboard consumer: every rvalid must match the oldest expectation
  // stamped for this cycle; overdue expectations are missing responses.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
        while (sb[s].size() > 0 && sb[s][0].stamp < cyc) begin
          e = sb[s].pop_front();
          tests_run++; tests_failed++;
          $display("[TB] FAIL rvalid_missing slot%0d cyc%0d: got rvalid=0, required rvalid=1 data=%h", s, cyc, e.data);
        end
        if (rv[s] === 1'b1) begin
          tests_run++;
          if (sb[s].size() == 0 || sb[s][0].stamp != cyc) begin
            tests_failed++;
            $display("[TB] FAIL rvalid_unexpected slot%0d cyc%0d: got rvalid=1 data=%h, required rvalid=0", s, cyc, rd[s]);
          end else begin
            e = sb[s].pop_front();
            if (rd[s] !== e.data) begin
              tests_failed++;
              $display("[TB] FAIL rdata slot%0d cyc%0d: got %h, required %h", s, cyc, rd[s], e.data);
            end else begin
              $display("[TB] read slot%0d cyc%0d data=%h ok", s, cyc, rd[s]);
            end
          end
        end else if (rv[s] !== 1'b0) begin
          tests_run++; tests_failed++;
          $display("[TB] FAIL rvalid_x slot%0d cyc%0d: got %b, required 0/1", s, cyc, rv[s]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if ({g[2*k], g[2*k+1], rv[2*k], rv[2*k+1], m_wen[k]} !== 5'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_flags inst%0d: got gnt=%b%b rv=%b%b wen=%b, required all 0",
                 k, g[2*k], g[2*k+1], rv[2*k], rv[2*k+1], m_wen[k]);
      end
      tests_run++;
      if (rd[2*k] !== 16'h0 || rd[2*k+1] !== 16'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset_rdata inst%0d: got %h/%h, required 0000/0000", k, rd[2*k], rd[2*k+1]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("[TB] reset released cyc%0d", cyc);
  endtask

  task automatic test_write_read();
    set_in(1, 1, 16'h0100, 16'h5555, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (g[2*k] !== 1'b1 || g[2*k+1] !== 1'b0 || m_wen[k] !== 1'b1 ||
          m_addr[k] !== 16'h0100 || m_wdata[k] !== 16'h5555) begin
        tests_failed++;
        $display("[TB] FAIL p0_write inst%0d: got gnt=%b%b wen=%b addr=%h wd=%h, required gnt=10 wen=1 addr=0100 wd=5555",
                 k, g[2*k], g[2*k+1], m_wen[k], m_addr[k], m_wdata[k]);
      end
    end
    $display("[TB] p0 write 0100=5555 cyc%0d", cyc);
    @(posedge clk); #1;
    set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0100, 16'h0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (g[2*k] !== 1'b0 || g[2*k+1] !== 1'b1 || m_wen[k] !== 1'b0 || m_addr[k] !== 16'h0100) begin
        tests_failed++;
        $display("[TB] FAIL p1_read_gnt inst%0d: got gnt=%b%b wen=%b addr=%h, required gnt=01 wen=0 addr=0100",
                 k, g[2*k], g[2*k+1], m_wen[k], m_addr[k]);
      end
      sb[2*k+1].push_back('{stamp: cyc + 1, data: 16'h5555});
    end
    $display("[TB] p1 read 0100 cyc%0d", cyc);
    @(posedge clk); #1;
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    int          ep;
    logic [15:0] a0, a1;
    for (int i = 0; i < 12; i++) begin
      a0 = 16'h0010 + 16'(i);
      a1 = 16'h0040 + 16'(i);
      set_in(1, 0, a0, 16'h0, 1, 0, a1, 16'h0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ep = (k == 0) ? ((i / 4) % 2) : (i % 2);
        tests_run++;
        if (g[2*k] !== (ep == 0) || g[2*k+1] !== (ep == 1) || m_addr[k] !== (ep == 1 ? a1 : a0)) begin
          tests_failed++;
          $display("[TB] FAIL burst_gnt inst%0d step%0d: got gnt=%b%b addr=%h, required port%0d addr=%h",
                   k, i, g[2*k], g[2*k+1], m_addr[k], ep, (ep == 1 ? a1 : a0));
        end
        sb[2*k+ep].push_back('{stamp: cyc + 1, data: pat(ep == 1 ? a1 : a0)});
      end
      $display("[TB] burst step%0d cyc%0d", i, cyc);
      @(posedge clk); #1;
    end
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_write_contention();
    rst_n = 1'b0;
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(1, 1, 16'h0200, 16'h1111, 1, 1, 16'h0200, 16'h2222);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (g[2*k] !== 1'b1 || g[2*k+1] !== 1'b0 || m_wdata[k] !== 16'h1111 || m_wen[k] !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL wcont_first inst%0d: got gnt=%b%b wd=%h wen=%b, required gnt=10 wd=1111 wen=1",
                 k, g[2*k], g[2*k+1], m_wdata[k], m_wen[k]);
      end
    end
    $display("[TB] contention write p0 cyc%0d", cyc);
    @(posedge clk); #1;
    set_in(0, 0, 16'h0, 16'h0, 1, 1, 16'h0200, 16'h2222);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (g[2*k] !== 1'b0 || g[2*k+1] !== 1'b1 || m_wdata[k] !== 16'h2222 || m_wen[k] !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL wcont_second inst%0d: got gnt=%b%b wd=%h wen=%b, required gnt=01 wd=2222 wen=1",
                 k, g[2*k], g[2*k+1], m_wdata[k], m_wen[k]);
      end
    end
    $display("[TB] contention write p1 cyc%0d", cyc);
    @(posedge clk); #1;
    set_in(1, 0, 16'h0200, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (g[2*k] !== 1'b1 || g[2*k+1] !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL wcont_read_gnt inst%0d: got gnt=%b%b, required 10", k, g[2*k], g[2*k+1]);
      end
      sb[2*k].push_back('{stamp: cyc + 1, data: 16'h2222});
    end
    $display("[TB] p0 read 0200 cyc%0d", cyc);
    @(posedge clk); #1;
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    set_in(1, 0, 16'h0030, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (g[2*k] !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL midrst_gnt inst%0d: got %b, required 1", k, g[2*k]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (rv[2*k] !== 1'b0 || rd[2*k] !== 16'h0) begin
        tests_failed++;
        $display("[TB] FAIL midrst_drop inst%0d: got rvalid=%b rdata=%h, required 0/0000", k, rv[2*k], rd[2*k]);
      end
    end
    $display("[TB] reset during read cyc%0d", cyc);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(1, 0, 16'h0031, 16'h0, 1, 0, 16'h0051, 16'h0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (g[2*k] !== 1'b1 || g[2*k+1] !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL midrst_contend inst%0d: got gnt=%b%b, required 10", k, g[2*k], g[2*k+1]);
      end
      sb[2*k].push_back('{stamp: cyc + 1, data: pat(16'h0031)});
    end
    $display("[TB] post-reset contention cyc%0d", cyc);
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (g[2*k] !== 1'b0 || g[2*k+1] !== 1'b0 || m_wen[k] !== 1'b0 ||
            m_addr[k] !== 16'h0 || m_wdata[k] !== 16'h0) begin
          tests_failed++;
          $display("[TB] FAIL idle inst%0d step%0d: got gnt=%b%b wen=%b addr=%h wd=%h, required all 0",
                   k, i, g[2*k], g[2*k+1], m_wen[k], m_addr[k], m_wdata[k]);
        end
      end
      if (i == 2) begin
        tests_run++;
        if (u_max4.run_cnt_q !== 4'd0 || u_max1.run_cnt_q !== 4'd0) begin
          tests_failed++;
          $display("[TB] FAIL idle_run_cnt: got %0d/%0d, required 0/0", u_max4.run_cnt_q, u_max1.run_cnt_q);
        end
      end
      $display("[TB] idle step%0d cyc%0d", i, cyc);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_write_read();
    test_burst();
    test_write_contention();
    test_reset_midop();
    test_idle();
    repeat (2) @(posedge clk);
    for (int s = 0; s < 4; s++) begin
      tests_run++;
      if (sb[s].size() != 0) begin
        tests_failed++;
        $display("[TB] FAIL sb_drain slot%0d: got %0d pending, required 0", s, sb[s].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
